// File: rtl/sparrow_pkg.sv
// sparrow_pkg: types shared by the load/store unit and the data-memory side.
//   mem_size_e  - access size, also carried on the dmem byte-enable lines
//   lsu_state_e - LSU transaction FSM states
//   is_misaligned() - alignment rule for a given size and byte offset
package sparrow_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    case (size)
      HALF_WORD: return off[0];
      WORD:      return off != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sparrow_lsu_if.sv
// sparrow_lsu_if: execute-request, writeback-response and data-memory signals
// of the load/store unit. Signal names keep the LSU-relative i_/o_ prefixes.
//   slave  - the LSU side (instantiated by sparrow_lsu)
//   master - the surrounding core / memory side
interface sparrow_lsu_if;
  import sparrow_pkg::*;

  // execute -> LSU request
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_wr_en;
  mem_size_e   i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_wr_data;
  // LSU -> writeback response
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rd_data;
  logic        o_rsp_misaligned;
  // LSU -> data memory
  logic        o_dmem_req;
  logic [31:0] o_dmem_addr;
  mem_size_e   o_dmem_byte_en;
  logic        o_dmem_wr_en;
  logic [31:0] o_dmem_wr_data;
  logic [31:0] i_dmem_rd_data;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_wr_en, i_req_size, i_req_unsigned, i_req_wr_data,
    output o_req_ready,
    output o_rsp_valid, o_rsp_rd_data, o_rsp_misaligned,
    input  i_rsp_ready,
    output o_dmem_req, o_dmem_addr, o_dmem_byte_en, o_dmem_wr_en, o_dmem_wr_data,
    input  i_dmem_rd_data
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_wr_en, i_req_size, i_req_unsigned, i_req_wr_data,
    input  o_req_ready,
    input  o_rsp_valid, o_rsp_rd_data, o_rsp_misaligned,
    output i_rsp_ready,
    input  o_dmem_req, o_dmem_addr, o_dmem_byte_en, o_dmem_wr_en, o_dmem_wr_data,
    output i_dmem_rd_data
  );

endinterface

// File: rtl/sparrow_lsu_load_align.sv
// sparrow_lsu_load_align: picks the addressed lane out of an aligned memory
// word and sign- or zero-extends it to 32 bits.
//   word        - full aligned word from memory
//   off         - byte offset within the word (addr[1:0])
//   size        - BYTE / HALF_WORD / WORD
//   is_unsigned - zero-extend instead of sign-extend (no effect for WORD)
//   result      - extended load value
module sparrow_lsu_load_align
  import sparrow_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] byte_shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign byte_shifted = word >> {off, 3'b000};
  assign lane_b       = byte_shifted[7:0];
  // Halfword lanes only ever start at byte 0 or 2, so only off[1] selects.
  assign lane_h       = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (size)
      BYTE:      result = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      HALF_WORD: result = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/sparrow_lsu.sv
// sparrow_lsu: load/store unit, initiator side of the core's data-memory port.
// Accepts one request from execute, checks alignment, makes one single-cycle
// dmem access, extends load data and returns the result to writeback.
// One transaction in flight at a time.
// Ports:
//   i_clk, i_reset - clock, synchronous active-high reset
//   bus            - sparrow_lsu_if.slave: request, response and dmem signals
//   o_perf_loads / o_perf_stores / o_perf_misaligned - saturating completion
//                    counters, present only with SPARROW_LSU_PERF_CNT_EN
// Parameter MEM_RD_LATENCY: 0 = read data valid in the request cycle,
//   1 = read data valid one cycle later.
module sparrow_lsu
  import sparrow_pkg::*;
#(
  parameter int unsigned MEM_RD_LATENCY = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  sparrow_lsu_if.slave bus
`ifdef SPARROW_LSU_PERF_CNT_EN
  ,
  output logic [31:0]  o_perf_loads,
  output logic [31:0]  o_perf_stores,
  output logic [31:0]  o_perf_misaligned
`endif
);

  if (MEM_RD_LATENCY > 1) begin : g_bad_latency
    $fatal(1, "sparrow_lsu: MEM_RD_LATENCY must be 0 or 1");
  end

  lsu_state_e  state, state_next;

  logic [31:0] req_addr_q;
  logic [31:0] req_wr_data_q;
  logic        req_wr_en_q;
  logic        req_unsigned_q;
  mem_size_e   req_size_q;

  logic [31:0] rsp_rd_data_q;
  logic        rsp_misaligned_q;

  logic        accept;
  logic        req_misaligned;
  logic        capture;
  logic [31:0] load_result;

  assign accept         = bus.i_req_valid && (state == IDLE) && !i_reset;
  assign req_misaligned = is_misaligned(bus.i_req_size, bus.i_req_addr[1:0]);
  // Latency-0 loads sample read data at the end of ACCESS; latency-1 loads
  // sample it at the end of WAIT.
  assign capture = ((state == ACCESS) && !req_wr_en_q && (MEM_RD_LATENCY == 0)) ||
                   (state == WAIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next          = state;
    bus.o_req_ready     = 1'b0;
    bus.o_rsp_valid     = 1'b0;
    bus.o_dmem_req      = 1'b0;
    bus.o_dmem_addr     = '0;
    bus.o_dmem_byte_en  = BYTE;
    bus.o_dmem_wr_en    = 1'b0;
    bus.o_dmem_wr_data  = '0;
    case (state)
      IDLE: begin
        bus.o_req_ready = !i_reset;
        if (accept) state_next = req_misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.o_dmem_req     = 1'b1;
        bus.o_dmem_addr    = req_addr_q;
        bus.o_dmem_byte_en = req_size_q;
        bus.o_dmem_wr_en   = req_wr_en_q;
        bus.o_dmem_wr_data = req_wr_data_q;
        state_next = (req_wr_en_q || (MEM_RD_LATENCY == 0)) ? RESP : WAIT;
      end
      WAIT: begin
        state_next = RESP;
      end
      RESP: begin
        bus.o_rsp_valid = 1'b1;
        if (bus.i_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response data is cleared on accept so stores and faults return 0
  // without a separate path; loads overwrite it on capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      req_addr_q       <= '0;
      req_wr_data_q    <= '0;
      req_wr_en_q      <= 1'b0;
      req_unsigned_q   <= 1'b0;
      req_size_q       <= BYTE;
      rsp_rd_data_q    <= '0;
      rsp_misaligned_q <= 1'b0;
    end else begin
      if (accept) begin
        req_addr_q       <= bus.i_req_addr;
        req_wr_data_q    <= bus.i_req_wr_data;
        req_wr_en_q      <= bus.i_req_wr_en;
        req_unsigned_q   <= bus.i_req_unsigned;
        req_size_q       <= bus.i_req_size;
        rsp_rd_data_q    <= '0;
        rsp_misaligned_q <= req_misaligned;
      end
      if (capture) rsp_rd_data_q <= load_result;
    end
  end

  assign bus.o_rsp_rd_data    = rsp_rd_data_q;
  assign bus.o_rsp_misaligned = rsp_misaligned_q;

  sparrow_lsu_load_align u_load_align (
    .word        (bus.i_dmem_rd_data),
    .off         (req_addr_q[1:0]),
    .size        (req_size_q),
    .is_unsigned (req_unsigned_q),
    .result      (load_result)
  );

`ifdef SPARROW_LSU_PERF_CNT_EN
  logic rsp_done;
  assign rsp_done = (state == RESP) && bus.i_rsp_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_perf_loads      <= '0;
      o_perf_stores     <= '0;
      o_perf_misaligned <= '0;
    end else if (rsp_done) begin
      if (rsp_misaligned_q) begin
        if (o_perf_misaligned != '1) o_perf_misaligned <= o_perf_misaligned + 32'd1;
      end else if (req_wr_en_q) begin
        if (o_perf_stores != '1) o_perf_stores <= o_perf_stores + 32'd1;
      end else begin
        if (o_perf_loads != '1) o_perf_loads <= o_perf_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sparrow_lsu.sv
// Testbench for sparrow_lsu: one instance per read latency (0 and 1) driven
// by the same request stream, each with its own memory and reference model.
module tb_sparrow_lsu;
  import sparrow_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_wr_en, req_unsigned, rsp_ready;
  logic [31:0] req_addr, req_wr_data;
  mem_size_e   req_size;
  int          mode;  // 0 random ready, 1 ready high, 2 ready low

  sparrow_lsu_if bus0();
  sparrow_lsu_if bus1();

  assign bus0.i_req_valid = req_valid;      assign bus1.i_req_valid = req_valid;
  assign bus0.i_req_addr = req_addr;        assign bus1.i_req_addr = req_addr;
  assign bus0.i_req_wr_en = req_wr_en;      assign bus1.i_req_wr_en = req_wr_en;
  assign bus0.i_req_size = req_size;        assign bus1.i_req_size = req_size;
  assign bus0.i_req_unsigned = req_unsigned; assign bus1.i_req_unsigned = req_unsigned;
  assign bus0.i_req_wr_data = req_wr_data;  assign bus1.i_req_wr_data = req_wr_data;
  assign bus0.i_rsp_ready = rsp_ready;      assign bus1.i_rsp_ready = rsp_ready;

`ifdef SPARROW_LSU_PERF_CNT_EN
  logic [31:0] pl [2];
  logic [31:0] ps [2];
  logic [31:0] pm [2];
`endif

  sparrow_lsu #(.MEM_RD_LATENCY(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(bus0)
`ifdef SPARROW_LSU_PERF_CNT_EN
    , .o_perf_loads(pl[0]), .o_perf_stores(ps[0]), .o_perf_misaligned(pm[0])
`endif
  );

  sparrow_lsu #(.MEM_RD_LATENCY(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(bus1)
`ifdef SPARROW_LSU_PERF_CNT_EN
    , .o_perf_loads(pl[1]), .o_perf_stores(ps[1]), .o_perf_misaligned(pm[1])
`endif
  );

  // ---------------- memory environment ----------------
  logic [31:0] env0 [256];
  logic [31:0] env1 [256];
  logic [31:0] rd1_q;

  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] a,
                                             input mem_size_e sz, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (sz)
      BYTE:      r[8*a[1:0] +: 8] = d[7:0];
      HALF_WORD: r[16*a[1] +: 16] = d[15:0];
      default:   r = d;
    endcase
    return r;
  endfunction

  assign bus0.i_dmem_rd_data = bus0.o_dmem_req ? env0[bus0.o_dmem_addr[9:2]] : 32'hDEADBEEF;
  assign bus1.i_dmem_rd_data = rd1_q;

  always @(posedge clk) begin
    if (bus0.o_dmem_req && bus0.o_dmem_wr_en)
      env0[bus0.o_dmem_addr[9:2]] <= lane_merge(env0[bus0.o_dmem_addr[9:2]], bus0.o_dmem_addr,
                                                bus0.o_dmem_byte_en, bus0.o_dmem_wr_data);
    if (bus1.o_dmem_req && bus1.o_dmem_wr_en)
      env1[bus1.o_dmem_addr[9:2]] <= lane_merge(env1[bus1.o_dmem_addr[9:2]], bus1.o_dmem_addr,
                                                bus1.o_dmem_byte_en, bus1.o_dmem_wr_data);
    rd1_q <= bus1.o_dmem_req ? env1[bus1.o_dmem_addr[9:2]] : $urandom;
  end

  // ---------------- reference model ----------------
  int          checks = 0;
  int          errors = 0;
  int          lat_of [2] = '{0, 1};
  logic [31:0] model_mem [2][256];
  bit          busy [2], retiring [2], ex_mis [2], ex_wr [2], ex_uns [2];
  int          n [2], lat [2], first_valid [2], done_cnt [2];
  logic [31:0] ex_addr [2], ex_wd [2], ex_data [2], got_data [2];
  mem_size_e   ex_size [2];
  bit          got_mis [2];
  int          m_ld [2], m_st [2], m_mis [2];
  bit          prev_rst = 1'b0;

  logic        s_ready [2], s_rv [2], s_mis [2], s_dreq [2], s_dwr [2];
  logic [31:0] s_rd [2], s_daddr [2], s_dwd [2];
  logic [1:0]  s_be [2];

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[lat%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out @%0t", nm, $time);
  endtask

  // Loads take the byte/halfword value arithmetically and fold it negative
  // when signed and the top bit of the lane is set.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input mem_size_e sz, input bit uns);
    longint x;
    int unsigned sh = 8 * (a % 4);
    case (sz)
      BYTE: begin
        x = (w >> sh) & 255;
        if (!uns && x >= 128) x = x - 256;
      end
      HALF_WORD: begin
        x = (w >> sh) & 65535;
        if (!uns && x >= 32768) x = x - 65536;
      end
      default: x = w;
    endcase
    return x[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                              input mem_size_e sz, input logic [31:0] d);
    int unsigned sh = 8 * (a % 4);
    logic [31:0] mask;
    mask = (sz == BYTE) ? (32'hFF << sh) : (sz == HALF_WORD) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic model_accept(input int k);
    bit mis;
    ex_addr[k] = req_addr; ex_wr[k] = req_wr_en; ex_size[k] = req_size;
    ex_uns[k] = req_unsigned; ex_wd[k] = req_wr_data;
    mis = (req_size == HALF_WORD && req_addr % 2 != 0) || (req_size == WORD && req_addr % 4 != 0);
    ex_mis[k] = mis;
    lat[k] = mis ? 1 : (req_wr_en ? 2 : 2 + lat_of[k]);
    ex_data[k] = '0;
    if (!mis && req_wr_en)
      model_mem[k][req_addr[9:2]] = model_store(model_mem[k][req_addr[9:2]], req_addr, req_size, req_wr_data);
    else if (!mis)
      ex_data[k] = model_load(model_mem[k][req_addr[9:2]], req_addr, req_size, req_unsigned);
    busy[k] = 1'b1;
    n[k] = 0;
    first_valid[k] = -1;
  endtask

  always @(negedge clk) begin
    s_ready[0] = bus0.o_req_ready;  s_ready[1] = bus1.o_req_ready;
    s_rv[0] = bus0.o_rsp_valid;     s_rv[1] = bus1.o_rsp_valid;
    s_rd[0] = bus0.o_rsp_rd_data;   s_rd[1] = bus1.o_rsp_rd_data;
    s_mis[0] = bus0.o_rsp_misaligned; s_mis[1] = bus1.o_rsp_misaligned;
    s_dreq[0] = bus0.o_dmem_req;    s_dreq[1] = bus1.o_dmem_req;
    s_daddr[0] = bus0.o_dmem_addr;  s_daddr[1] = bus1.o_dmem_addr;
    s_be[0] = bus0.o_dmem_byte_en;  s_be[1] = bus1.o_dmem_byte_en;
    s_dwr[0] = bus0.o_dmem_wr_en;   s_dwr[1] = bus1.o_dmem_wr_en;
    s_dwd[0] = bus0.o_dmem_wr_data; s_dwd[1] = bus1.o_dmem_wr_data;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk(k, "req_ready_in_reset", 32'(s_ready[k]), 32'd0);
        if (prev_rst) begin
          chk(k, "rsp_valid_after_reset", 32'(s_rv[k]), 32'd0);
          chk(k, "dmem_req_after_reset", 32'(s_dreq[k]), 32'd0);
          chk(k, "rsp_rd_data_after_reset", s_rd[k], 32'd0);
          chk(k, "rsp_mis_after_reset", 32'(s_mis[k]), 32'd0);
          chk(k, "dmem_addr_after_reset", s_daddr[k], 32'd0);
        end
        busy[k] = 1'b0; retiring[k] = 1'b0;
        m_ld[k] = 0; m_st[k] = 0; m_mis[k] = 0;
      end else begin
        if (retiring[k]) begin
          busy[k] = 1'b0;
          retiring[k] = 1'b0;
        end
        if (!busy[k]) begin
          chk(k, "req_ready_idle", 32'(s_ready[k]), 32'd1);
          chk(k, "rsp_valid_idle", 32'(s_rv[k]), 32'd0);
          chk(k, "dmem_req_idle", 32'(s_dreq[k]), 32'd0);
          if (req_valid) model_accept(k);
        end else begin
          n[k]++;
          chk(k, "req_ready_busy", 32'(s_ready[k]), 32'd0);
          chk(k, "dmem_req", 32'(s_dreq[k]), 32'(!ex_mis[k] && n[k] == 1));
          if (!ex_mis[k] && n[k] == 1) begin
            chk(k, "dmem_addr", s_daddr[k], ex_addr[k]);
            chk(k, "dmem_byte_en", 32'(s_be[k]), 32'(ex_size[k]));
            chk(k, "dmem_wr_en", 32'(s_dwr[k]), 32'(ex_wr[k]));
            chk(k, "dmem_wr_data", s_dwd[k], ex_wd[k]);
          end
          chk(k, "rsp_valid", 32'(s_rv[k]), 32'(n[k] >= lat[k]));
          if (n[k] >= lat[k]) begin
            chk(k, "rsp_rd_data", s_rd[k], ex_data[k]);
            chk(k, "rsp_misaligned", 32'(s_mis[k]), 32'(ex_mis[k]));
            if (first_valid[k] < 0) first_valid[k] = n[k];
            if (rsp_ready) begin
              retiring[k] = 1'b1;
              got_data[k] = s_rd[k];
              got_mis[k] = s_mis[k];
              done_cnt[k]++;
              if (ex_mis[k]) m_mis[k]++;
              else if (ex_wr[k]) m_st[k]++;
              else m_ld[k]++;
            end
          end
        end
      end
    end
    prev_rst = rst;
  end

  // ---------------- stimulus ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) rsp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic set_mode(input int m);
    mode = m;
    if (m == 1) rsp_ready = 1'b1;
    if (m == 2) rsp_ready = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input bit wr, input mem_size_e sz,
                       input bit uns, input logic [31:0] d);
    int t = 0;
    while (!(bus0.o_req_ready && bus1.o_req_ready)) begin
      if (t >= 50) begin
        timeout("wait_req_ready");
        do_reset(2);
        t = 0;
      end
      @(posedge clk);
      #1;
      t++;
    end
    req_addr = a; req_wr_en = wr; req_size = sz; req_unsigned = uns; req_wr_data = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wr_en = 1'($urandom); req_unsigned = 1'($urandom);
    req_wr_data = $urandom; req_size = mem_size_e'($urandom_range(0, 2));
  endtask

  task automatic wait_done();
    int t = 0;
    while (busy[0] || busy[1]) begin
      if (t >= 60) begin
        timeout("wait_response");
        do_reset(2);
        return;
      end
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic wait_both_valid();
    int t = 0;
    while (!(bus0.o_rsp_valid && bus1.o_rsp_valid)) begin
      if (t >= 20) begin
        timeout("wait_rsp_valid");
        return;
      end
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic txn(input logic [31:0] a, input bit wr, input mem_size_e sz,
                     input bit uns, input logic [31:0] d);
    issue(a, wr, sz, uns, d);
    wait_done();
  endtask

  task automatic expect_rsp(input string nm, input logic [31:0] d, input bit mis,
                            input int l0, input int l1);
    for (int k = 0; k < 2; k++) begin
      chk(k, {nm, "_data"}, got_data[k], d);
      chk(k, {nm, "_mis"}, 32'(got_mis[k]), 32'(mis));
      chk(k, {nm, "_latency"}, 32'(first_valid[k]), 32'((k == 0) ? l0 : l1));
    end
  endtask

`ifdef SPARROW_LSU_PERF_CNT_EN
  task automatic check_perf(input string nm, input int ld, input int st, input int mi);
    for (int k = 0; k < 2; k++) begin
      chk(k, {nm, "_perf_loads"}, pl[k], 32'(ld));
      chk(k, {nm, "_perf_stores"}, ps[k], 32'(st));
      chk(k, {nm, "_perf_misaligned"}, pm[k], 32'(mi));
    end
  endtask
`endif

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_wr_en = 1'b0; req_size = BYTE;
    req_unsigned = 1'b0; req_wr_data = '0;
    set_mode(1);
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (i == 32'h40) w = 32'h8899AABB;
      env0[i] = w; env1[i] = w;
      model_mem[0][i] = w; model_mem[1][i] = w;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
`ifdef SPARROW_LSU_PERF_CNT_EN
    check_perf("reset", 0, 0, 0);
`endif

    // loads from 0x100 = 0x8899AABB
    txn(32'h101, 0, BYTE, 0, 32'h0);       expect_rsp("lb_101", 32'hFFFFFFAA, 0, 2, 3);
    txn(32'h103, 0, BYTE, 1, 32'h0);       expect_rsp("lbu_103", 32'h00000088, 0, 2, 3);
    txn(32'h102, 0, HALF_WORD, 0, 32'h0);  expect_rsp("lh_102", 32'hFFFF8899, 0, 2, 3);
    txn(32'h100, 0, HALF_WORD, 1, 32'h0);  expect_rsp("lhu_100", 32'h0000AABB, 0, 2, 3);
    txn(32'h100, 0, WORD, 0, 32'h0);       expect_rsp("lw_100", 32'h8899AABB, 0, 2, 3);

    // byte store into lane 2, then read back the whole word
    txn(32'h102, 1, BYTE, 0, 32'h12345678); expect_rsp("sb_102", 32'h0, 0, 2, 2);
    chk(0, "mem_after_sb", env0[32'h40], 32'h8878AABB);
    chk(1, "mem_after_sb", env1[32'h40], 32'h8878AABB);
    txn(32'h100, 0, WORD, 0, 32'h0);       expect_rsp("lw_after_sb", 32'h8878AABB, 0, 2, 3);

    // misaligned accesses never reach memory
    txn(32'h101, 1, HALF_WORD, 0, 32'hCAFE); expect_rsp("sh_101", 32'h0, 1, 1, 1);
    txn(32'h102, 0, WORD, 0, 32'h0);         expect_rsp("lw_102", 32'h0, 1, 1, 1);
`ifdef SPARROW_LSU_PERF_CNT_EN
    check_perf("after_basic", 6, 1, 2);
`endif

    // writeback backpressure
    set_mode(2);
    issue(32'h100, 0, WORD, 0, 32'h0);
    wait_both_valid();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    set_mode(1);
    wait_done();
    expect_rsp("lw_backpressure", 32'h8878AABB, 0, 2, 3);

    // reset in ACCESS, then in RESP: transaction dropped
    issue(32'h100, 0, WORD, 0, 32'h0);
    do_reset(2);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    set_mode(2);
    issue(32'h104, 0, BYTE, 0, 32'h0);
    wait_both_valid();
    do_reset(2);
    set_mode(1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
`ifdef SPARROW_LSU_PERF_CNT_EN
    check_perf("after_mid_reset", 0, 0, 0);
`endif

    // randomized traffic with random writeback stalls
    set_mode(0);
    for (int i = 0; i < 200; i++) begin
      txn(32'($urandom_range(0, 1023)), 1'($urandom), mem_size_e'($urandom_range(0, 2)),
          1'($urandom), $urandom);
    end
    set_mode(1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
`ifdef SPARROW_LSU_PERF_CNT_EN
    for (int k = 0; k < 2; k++) begin
      chk(k, "final_perf_loads", pl[k], 32'(m_ld[k]));
      chk(k, "final_perf_stores", ps[k], 32'(m_st[k]));
      chk(k, "final_perf_misaligned", pm[k], 32'(m_mis[k]));
    end
`endif
    for (int i = 0; i < 256; i++) begin
      chk(0, "final_mem", env0[i], model_mem[0][i]);
      chk(1, "final_mem", env1[i], model_mem[1][i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
